// File: rtl/serial_word_adder_pkg.sv
// Shared definitions for the serial word adder slice.
// Provides:
//   SLICE_W    width of the single ripple slice reused every cycle
//   state_t    controller state encoding
//   ADD / SUB  values of the mode input
package serial_word_adder_pkg;

   localparam int SLICE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic ADD = 1'b0;
   localparam logic SUB = 1'b1;

endpackage

// File: rtl/serial_word_adder_if.sv
// Handshake and data bundle between the sequencing control logic and the
// serial word adder.
//   master : control side  - drives start/mode/a/b, observes status/result
//   slave  : adder side    - receives request, returns busy/done/sum/cout/ovf
interface serial_word_adder_if #(
   parameter int WIDTH = 16
) ();

   logic             start;
   logic             mode;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output start, mode, a, b,
      input  busy, done, sum, cout, ovf
   );

   modport slave (
      input  start, mode, a, b,
      output busy, done, sum, cout, ovf
   );

endinterface

// File: rtl/serial_word_adder_nibble_adder.sv
// Combinational 4-bit ripple-carry slice.
// Ports:
//   a, b  in   slice operands
//   cin   in   carry into bit 0
//   s     out  slice sum
//   cout  out  carry out of bit 3
//   c3    out  carry into bit 3 (with cout gives signed overflow)
module nibble_adder
   import serial_word_adder_pkg::*;
(
   input  logic [SLICE_W-1:0] a,
   input  logic [SLICE_W-1:0] b,
   input  logic               cin,
   output logic [SLICE_W-1:0] s,
   output logic               cout,
   output logic               c3
);

   logic [SLICE_W:0] c;

   always_comb begin
      c    = '0;
      s    = '0;
      c[0] = cin;
      for (int i = 0; i < SLICE_W; i++) begin
         s[i]   = a[i] ^ b[i] ^ c[i];
         c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
      end
   end

   assign cout = c[SLICE_W];
   assign c3   = c[SLICE_W-1];

endmodule

// File: rtl/serial_word_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor built around one 4-bit ripple slice.
// One nibble is processed per clock, least significant first, with the
// inter-slice carry held in a flop.
// Ports:
//   clk   in   rising-edge clock
//   rst   in   asynchronous active-high reset
//   bus   slave modport: start/mode/a/b in, busy/done/sum/cout/ovf out
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; previous result held
// RUN   | one slice per cycle, idx selects the nibble
// DONE  | single cycle, done=1; start here chains straight into RUN
module serial_word_adder
   import serial_word_adder_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input logic               clk,
   input logic               rst,
   serial_word_adder_if.slave bus
);

   localparam int NSLICE = WIDTH / SLICE_W;
   localparam int IDX_W  = $clog2(NSLICE);

   if ((WIDTH % SLICE_W) != 0 || WIDTH < 8) begin : g_width_check
      $error("serial_word_adder: WIDTH must be a multiple of 4 and >= 8");
   end

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   opa_q, opb_q, sum_q;
   logic [IDX_W-1:0]   idx_q;
   logic               carry_q, cout_q, ovf_q;
   logic               busy, done;

   logic               start_acc, last_slice;
   int                 lsb;
   logic [SLICE_W-1:0] slice_a, slice_b, slice_s;
   logic               slice_cout, slice_c3;

   // start is honoured only when the datapath is not mid-operation
   assign start_acc  = bus.start && (state_q == IDLE || state_q == DONE);
   assign last_slice = (idx_q == IDX_W'(NSLICE - 1));

   always_comb begin
      lsb     = int'(idx_q) * SLICE_W;
      slice_a = opa_q[lsb +: SLICE_W];
      slice_b = opb_q[lsb +: SLICE_W];
   end

   nibble_adder u_nibble (
      .a    (slice_a),
      .b    (slice_b),
      .cin  (carry_q),
      .s    (slice_s),
      .cout (slice_cout),
      .c3   (slice_c3)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start) state_d = RUN;
         RUN:     if (last_slice) state_d = DONE;
         DONE:    state_d = bus.start ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state_q)
         RUN:     busy = 1'b1;
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   // Subtract is a + ~b + 1: invert B once at capture and seed the carry
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         opa_q   <= '0;
         opb_q   <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (start_acc) begin
         opa_q   <= bus.a;
         opb_q   <= bus.b ^ {WIDTH{bus.mode == SUB}};
         carry_q <= (bus.mode == SUB);
         idx_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (state_q == RUN) begin
         sum_q[lsb +: SLICE_W] <= slice_s;
         carry_q               <= slice_cout;
         if (last_slice) begin
            idx_q  <= '0;
            cout_q <= slice_cout;
            ovf_q  <= slice_c3 ^ slice_cout;
         end else begin
            idx_q  <= idx_q + 1'b1;
         end
      end
   end

   assign bus.busy = busy;
   assign bus.done = done;
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;
   assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_word_adder.sv
module tb_serial_word_adder;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int n_checks = 0;
   int n_fail   = 0;

   serial_word_adder_if #(.WIDTH(16)) bus ();

   serial_word_adder #(.WIDTH(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   // Waits (bounded) for done, counting busy cycles seen on the way.
   task automatic wait_done(output int busy_cycles, output bit seen);
      busy_cycles = 0;
      seen        = 1'b0;
      for (int n = 0; n < 20; n++) begin
         if (bus.done) begin
            seen = 1'b1;
            break;
         end
         if (bus.busy) busy_cycles++;
         @(posedge clk); #1;
      end
   endtask

   task automatic check_result(input string tag, input logic [15:0] es,
                               input logic ec, input logic eo);
      check({tag, " sum"},  32'(bus.sum),  32'(es));
      check({tag, " cout"}, 32'(bus.cout), 32'(ec));
      check({tag, " ovf"},  32'(bus.ovf),  32'(eo));
   endtask

   task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                         input logic md, input logic [15:0] es, input logic ec, input logic eo);
      int  bc;
      bit  seen;
      @(negedge clk);
      bus.start = 1'b1; bus.a = av; bus.b = bv; bus.mode = md;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.a = ~av; bus.b = ~bv; bus.mode = ~md;
      wait_done(bc, seen);
      check({tag, " done seen"}, 32'(seen), 32'd1);
      check({tag, " busy cycles"}, 32'(bc), 32'd4);
      check({tag, " busy&done"}, 32'(bus.busy), 32'd0);
      check_result(tag, es, ec, eo);
      @(posedge clk); #1;
      check({tag, " done pulse"}, 32'(bus.done), 32'd0);
      @(posedge clk); #1;
      check_result({tag, " held"}, es, ec, eo);
   endtask

   initial begin
      int  bc;
      bit  seen;
      bus.start = 1'b0; bus.mode = 1'b0; bus.a = '0; bus.b = '0;
      #12;
      check("reset busy", 32'(bus.busy), 32'd0);
      check("reset done", 32'(bus.done), 32'd0);
      check_result("reset", 16'h0000, 1'b0, 1'b0);
      @(negedge clk); rst = 1'b0;

      run_op("add basic",   16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
      run_op("add ripple",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
      run_op("add ovf",     16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
      run_op("sub pos",     16'h000D, 16'h0003, 1'b1, 16'h000A, 1'b1, 1'b0);
      run_op("sub neg",     16'h0003, 16'h000D, 1'b1, 16'hFFF6, 1'b0, 1'b0);
      run_op("sub ovf",     16'h7FFF, 16'hFFFF, 1'b1, 16'h8000, 1'b0, 1'b1);

      // start with new operands while busy must be ignored
      @(negedge clk);
      bus.start = 1'b1; bus.a = 16'h1234; bus.b = 16'h4321; bus.mode = 1'b0;
      @(posedge clk); #1;
      bus.a = 16'h1111; bus.b = 16'h2222; bus.mode = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.a = 16'hFFFF; bus.b = 16'hFFFF;
      wait_done(bc, seen);
      check("ignore done seen", 32'(seen), 32'd1);
      check_result("ignore", 16'h5555, 1'b0, 1'b0);
      @(posedge clk); #1;

      // back-to-back: start held through DONE
      @(negedge clk);
      bus.start = 1'b1; bus.a = 16'h0001; bus.b = 16'h0002; bus.mode = 1'b0;
      @(posedge clk); #1;
      bus.a = 16'h0F0F; bus.b = 16'h0101;
      wait_done(bc, seen);
      check("b2b first seen", 32'(seen), 32'd1);
      check_result("b2b first", 16'h0003, 1'b0, 1'b0);
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("b2b rerun busy", 32'(bus.busy), 32'd1);
      check("b2b rerun done", 32'(bus.done), 32'd0);
      check("b2b cleared sum", 32'(bus.sum), 32'h0000);
      @(posedge clk); #1;
      check("b2b partial1", 32'(bus.sum), 32'h0000);
      @(posedge clk); #1;
      check("b2b partial2", 32'(bus.sum), 32'h0010);
      wait_done(bc, seen);
      check("b2b second seen", 32'(seen), 32'd1);
      check_result("b2b second", 16'h1010, 1'b0, 1'b0);
      @(posedge clk); #1;

      // async reset mid-RUN after two slices
      @(negedge clk);
      bus.start = 1'b1; bus.a = 16'h5A5A; bus.b = 16'h1111; bus.mode = 1'b0;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("pre-rst partial", 32'(bus.sum), 32'h006B);
      check("pre-rst busy", 32'(bus.busy), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("rst busy", 32'(bus.busy), 32'd0);
      check("rst done", 32'(bus.done), 32'd0);
      check_result("rst", 16'h0000, 1'b0, 1'b0);
      @(negedge clk); rst = 1'b0;
      run_op("post-rst", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
